mem_arbiter: RTL

//   Shares the single main-memory port between two cache controllers
//   (requester 0 = instruction cache, requester 1 = data cache).
//   - Accepts level-held Strobe requests and picks one winner.
//   - Drives one memory transaction and times the fixed memory latency with an internal wait-state counter.
//   - Returns a one-cycle Ready pulse to the winner.

---
 rtl/mem_arbiter_if.sv | 44 ++++
 rtl/mem_arbiter.sv | 124 ++++++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// Bus bundle between two cache controllers, the arbiter, and main memory.
// master = arbiter side (drives memory and the Ready/RData returns); slave = environment side.
interface mem_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  logic          Strobe0;
  logic          RW0;
  logic [AW-1:0] Addr0;
  logic [DW-1:0] WData0;
  logic          Ready0;
  logic [DW-1:0] RData0;

  logic          Strobe1;
  logic          RW1;
  logic [AW-1:0] Addr1;
  logic [DW-1:0] WData1;
  logic          Ready1;
  logic [DW-1:0] RData1;

  logic          MStrobe;
  logic          MRW;
  logic [AW-1:0] MAddr;
  logic [DW-1:0] MWData;
  logic [DW-1:0] MRData;
  logic [1:0]    Grant;
  logic          Busy;

  modport master (
    input  Strobe0, RW0, Addr0, WData0,
    input  Strobe1, RW1, Addr1, WData1,
    input  MRData,
    output Ready0, RData0, Ready1, RData1,
    output MStrobe, MRW, MAddr, MWData, Grant, Busy
  );

  modport slave (
    output Strobe0, RW0, Addr0, WData0,
    output Strobe1, RW1, Addr1, WData1,
    output MRData,
    input  Ready0, RData0, Ready1, RData1,
    input  MStrobe, MRW, MAddr, MWData, Grant, Busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester main-memory arbiter with a fixed-latency wait-state counter.
// Define ARB_FIXED_PRI_EN for fixed priority (requester 1 wins ties); default is round-robin.
module mem_arbiter #(
  parameter int AW          = 8,
  parameter int DW          = 8,
  parameter int WAIT_CYCLES = 4
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.master bus
);
  localparam int CW = $clog2(WAIT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          last_reg, last_next;
  logic          served_reg, served_next;
  logic [1:0]    grant_reg, grant_next;
  logic [AW-1:0] maddr_reg, maddr_next;
  logic [DW-1:0] mwdata_reg, mwdata_next;
  logic          mrw_reg, mrw_next;

  logic [1:0] strobe;
  logic [1:0] eligible;
  logic [1:0] ready;
  logic       win;

  assign strobe = {bus.Strobe1, bus.Strobe0};

  // The requester served last is locked out for the first IDLE cycle after DONE.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_req
      assign eligible[gi] = strobe[gi] && !(served_reg && (last_reg == 1'(gi)));
      assign ready[gi]    = (state_reg == DONE) && grant_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      last_reg   <= 1'b1;
      served_reg <= 1'b0;
      grant_reg  <= '0;
      maddr_reg  <= '0;
      mwdata_reg <= '0;
      mrw_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      last_reg   <= last_next;
      served_reg <= served_next;
      grant_reg  <= grant_next;
      maddr_reg  <= maddr_next;
      mwdata_reg <= mwdata_next;
      mrw_reg    <= mrw_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    last_next   = last_reg;
    served_next = served_reg;
    grant_next  = grant_reg;
    maddr_next  = maddr_reg;
    mwdata_next = mwdata_reg;
    mrw_next    = mrw_reg;
    win         = 1'b0;

    case (state_reg)
      IDLE: begin
        served_next = 1'b0;
        if (|eligible) begin
          if (eligible == 2'b11) begin
`ifdef ARB_FIXED_PRI_EN
            win = 1'b1;
`else
            win = ~last_reg;
`endif
          end else begin
            win = eligible[1];
          end
          grant_next  = win ? 2'b10 : 2'b01;
          last_next   = win;
          maddr_next  = win ? bus.Addr1  : bus.Addr0;
          mwdata_next = win ? bus.WData1 : bus.WData0;
          mrw_next    = win ? bus.RW1    : bus.RW0;
          state_next  = ISSUE;
        end
      end
      ISSUE: begin
        cnt_next   = CW'(WAIT_CYCLES - 1);
        state_next = WAIT;
      end
      WAIT: begin
        if (cnt_reg == '0) begin
          state_next = DONE;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      DONE: begin
        grant_next  = 2'b00;
        served_next = 1'b1;
        state_next  = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.MStrobe = (state_reg == ISSUE);
  assign bus.Busy    = (state_reg != IDLE);
  assign bus.Grant   = grant_reg;
  assign bus.MAddr   = maddr_reg;
  assign bus.MWData  = mwdata_reg;
  assign bus.MRW     = mrw_reg;
  assign bus.Ready0  = ready[0];
  assign bus.Ready1  = ready[1];
  assign bus.RData0  = ready[0] ? bus.MRData : '0;
  assign bus.RData1  = ready[1] ? bus.MRData : '0;
endmodule
